// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DW_BYTES = 8;
    localparam int DW_BITS  = DW_BYTES * 8;
    localparam int DW_SHIFT = $clog2(DW_BYTES);
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // Any set bit above the doubleword index field means the access is out of range.
    function automatic logic range_fault(input logic [63:0] addr, input int idx_w);
        return (addr >> (idx_w + DW_SHIFT)) != 64'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : Single-port synchronous doubleword storage with registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [DW_BITS-1:0] wdata_i,
    output logic [DW_BITS-1:0] rdata_o
);

    logic [DW_BITS-1:0] mem_q [DEPTH];
    logic [DW_BITS-1:0] rdata_q;

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clock) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Multicycle load/store responder with programmable wait states.
//               Define DMEM_MISALIGN_TRAP_EN to fault on addr[2:0] != 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [63:0]        req_addr,
    input  logic [DW_BITS-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [DW_BITS-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               busy
);

    localparam int             IDX_W     = $clog2(DEPTH);
    localparam logic           NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic               fault_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DW_BITS-1:0] wdata_q;
    logic               req_ready_q;
    logic               busy_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               rd_sel_q;

    logic               fault_d;
    logic               in_idle_d;
    logic               go_resp_d;
    logic [IDX_W-1:0]   arr_idx_d;
    logic [DW_BITS-1:0] arr_wdata_d;
    logic               arr_we_d;
    logic [DW_BITS-1:0] arr_rdata;

    always_comb begin
        fault_d = range_fault(req_addr, IDX_W);
`ifdef DMEM_MISALIGN_TRAP_EN
        fault_d = fault_d | (req_addr[DW_SHIFT-1:0] != '0);
`endif
    end

    // With zero wait states the array is accessed on the acceptance edge itself,
    // so the request inputs feed it directly instead of the latched copies.
    always_comb begin
        in_idle_d   = (state_q == IDLE);
        go_resp_d   = (in_idle_d && req_valid && NO_WAIT) ||
                      ((state_q == WAIT) && (cnt_q == '0));
        arr_idx_d   = in_idle_d ? req_addr[IDX_W+DW_SHIFT-1:DW_SHIFT] : idx_q;
        arr_wdata_d = in_idle_d ? req_wdata : wdata_q;
        arr_we_d    = go_resp_d && (in_idle_d ? (req_write && !fault_d)
                                              : (write_q && !fault_q));
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock   (clock),
        .en_i    (go_resp_d),
        .we_i    (arr_we_d),
        .idx_i   (arr_idx_d),
        .wdata_i (arr_wdata_d),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            fault_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        fault_q     <= fault_d;
                        idx_q       <= req_addr[IDX_W+DW_SHIFT-1:DW_SHIFT];
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (NO_WAIT) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= fault_d;
                            rd_sel_q    <= !req_write && !fault_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fault_q;
                        rd_sel_q    <= !write_q && !fault_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rd_sel_q    <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rd_sel_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench; one instance with two wait
//               states, one with none.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_write, req_ready, rsp_valid, rsp_err, busy;
    logic [63:0] req_addr, req_wdata, rsp_rdata;
    logic        reset0, req_valid0, req_write0, req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [63:0] req_addr0, req_wdata0, rsp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
    );

    // One request on the two-wait-state instance; lat counts edges from acceptance
    // (acceptance edge = 1) to the first edge after which rsp_valid is seen, -1 on timeout.
    task automatic xact(input logic wr, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int lat);
        int g = 0;
        @(negedge clock);
        while (!req_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1; rd = '0; er = 1'b0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        if (rsp_valid) begin
            rd = rsp_rdata;
            er = rsp_err;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset0 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", rsp_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if ({req_ready0, rsp_valid0, rsp_err0, busy0} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_dut0 got %b exp 1000", {req_ready0, rsp_valid0, rsp_err0, busy0});
        end
        @(negedge clock);
        reset = 1'b0; reset0 = 1'b0;
    endtask

    task automatic test_store_load();
        logic [63:0] rd; logic er; int lat;
        xact(1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency got %0d exp 3", lat); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got %b exp 0", er); end
        n_checks++; if (rd !== 64'd0) begin n_fail++; $display("FAIL store_rdata got %h exp 0", rd); end
        xact(1'b0, 64'h40, 64'd0, rd, er, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency got %0d exp 3", lat); end
        n_checks++; if (rd !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL load_rdata got %h exp deadbeef01234567", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_err got %b exp 0", er); end
    endtask

    task automatic test_range_fault();
        logic [63:0] rd; logic er; int lat;
        xact(1'b1, 64'h000, 64'h0AAA, rd, er, lat);
        xact(1'b1, 64'h800, 64'hFFFF, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL range_store_err got %b exp 1", er); end
        xact(1'b0, 64'h800, 64'd0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL range_load got err %b data %h exp err 1 data 0", er, rd); end
        xact(1'b0, 64'h000, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h0AAA) begin n_fail++; $display("FAIL range_unchanged got %h exp aaa", rd); end
        xact(1'b1, 64'h7F8, 64'h0000_07F8_CAFE_0001, rd, er, lat);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_index_err got %b exp 0", er); end
        xact(1'b0, 64'h7F8, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h0000_07F8_CAFE_0001) begin n_fail++; $display("FAIL last_index_rdata got %h exp 7f8cafe0001", rd); end
        xact(1'b0, 64'h8000_0000_0000_0040, 64'd0, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL high_bit_err got %b exp 1", er); end
    endtask

    task automatic test_misalign();
        logic [63:0] rd; logic er; int lat;
        logic        exp_err;
        logic [63:0] exp_data;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_err = 1'b1; exp_data = 64'h2222;
`else
        exp_err = 1'b0; exp_data = 64'h1111;
`endif
        xact(1'b1, 64'h40, 64'h2222, rd, er, lat);
        xact(1'b1, 64'h43, 64'h1111, rd, er, lat);
        n_checks++; if (er !== exp_err) begin n_fail++; $display("FAIL misalign_err got %b exp %b", er, exp_err); end
        xact(1'b0, 64'h40, 64'd0, rd, er, lat);
        n_checks++; if (rd !== exp_data) begin n_fail++; $display("FAIL misalign_data got %h exp %h", rd, exp_data); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat;
        int          seen = 0;
        xact(1'b1, 64'h10, 64'h7777, rd, er, lat);
        @(negedge clock);
        while (!req_ready) @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'h5555;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({req_ready, busy, rsp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL mid_reset_outputs got %b exp 100", {req_ready, busy, rsp_valid});
        end
        repeat (4) begin
            @(posedge clock); #1;
            if (rsp_valid) seen++;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (rsp_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_rsp got %0d exp 0", seen); end
        xact(1'b0, 64'h10, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h7777) begin n_fail++; $display("FAIL mid_dropped_store got %h exp 7777", rd); end
    endtask

    task automatic test_ignore_busy();
        logic [63:0] rd; logic er; int lat;
        int          seen = 0;
        xact(1'b1, 64'h20, 64'h9999, rd, er, lat);
        @(negedge clock);
        while (!req_ready) @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = 64'h3333;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (rsp_valid) seen++;
            @(negedge clock);
            req_addr = 64'h20; req_wdata = 64'h4444;
            req_valid = busy && (i % 2 == 0);
        end
        req_valid = 1'b0;
        n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL busy_one_rsp got %0d exp 1", seen); end
        xact(1'b0, 64'h20, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h9999) begin n_fail++; $display("FAIL busy_ignored got %h exp 9999", rd); end
        xact(1'b0, 64'h18, 64'd0, rd, er, lat);
        n_checks++; if (rd !== 64'h3333) begin n_fail++; $display("FAIL busy_accepted got %h exp 3333", rd); end
    endtask

    task automatic test_back_to_back();
        logic        wr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] ad  [4] = '{64'h00, 64'h08, 64'h00, 64'h08};
        logic [63:0] wd  [4] = '{64'hA0A0, 64'hB8B8, 64'h0, 64'h0};
        logic [63:0] exd [4] = '{64'h0, 64'h0, 64'hA0A0, 64'hB8B8};
        int          acc [4];
        req_valid0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int g = 0;
            @(negedge clock);
            while (!req_ready0 && g < 10) begin
                @(negedge clock);
                g++;
            end
            req_write0 = wr[i]; req_addr0 = ad[i]; req_wdata0 = wd[i];
            @(posedge clock); #1;
            acc[i] = cyc;
            n_checks++; if ({rsp_valid0, rsp_err0} !== 2'b10) begin
                n_fail++; $display("FAIL b2b_rsp[%0d] got valid/err %b exp 10", i, {rsp_valid0, rsp_err0});
            end
            n_checks++; if (rsp_rdata0 !== exd[i]) begin
                n_fail++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rsp_rdata0, exd[i]);
            end
            if (i > 0) begin
                n_checks++; if (acc[i] - acc[i-1] !== 2) begin
                    n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 2", i, acc[i] - acc[i-1]);
                end
            end
        end
        req_valid0 = 1'b0;
    endtask

    initial begin
        req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        test_reset();
        test_store_load();
        test_range_fault();
        test_misalign();
        test_reset_mid();
        test_ignore_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached before end of test");
        $fatal(1);
    end

endmodule

`default_nettype wire
